martian_date_counter: RTL and testbench
=======================================

// Module: martian_date_counter
// PURPOSE
//   Sequential sol/month/year counter for the Darian (Martian) calendar.
//   Sits in a loop with martian_days:
//     - drives martian_days M and LY;
//     - consumes its D27/D28 month-length flags;
//     - advances the date by one sol per sol_tick.
//   Supplies current date and rollover pulses to downstream display/event logic.
// PARAMETERS
//   YEAR_W   12   width of year counter (wraps modulo 2**YEAR_W)
// PORTS
//   clk         in   1       single clock, all state on rising edge
//   reset       in   1       synchronous, active-high
//   sol_tick    in   1       advance date by one sol (1-cycle strobe)
//   load        in   1       load date from load_* inputs
//   load_year   in   YEAR_W  year to load
//   load_month  in   5       month to load, legal 0..23
//   load_sol    in   5       sol to load, legal 1..28
//   D27         in   1       from martian_days: current month has 27 sols
//   D28         in   1       from martian_days: current month has 28 sols
//   year        out  YEAR_W  current year (registered)
//   M           out  5       current month 0..23 (registered), to martian_days
//   sol         out  5       current sol 1..28 (registered)
//   LY          out  1       current year is leap (registered), to martian_days
//   month_end   out  1       1-cycle pulse: tick crossed a month boundary
//   year_end    out  1       1-cycle pulse: tick crossed month 23 into month 0
//   load_err    out  1       1-cycle pulse: load rejected
//   err         out  1       sticky: illegal D27/D28 seen on a tick
// BEHAVIOUR
//   Reset (sync, high):
//     year=0, M=0, sol=1, internal yr_mod10=0, LY=1 (year 0 is leap),
//     all pulses 0, err=0.
//   Month length:
//     len = 27 if {D27,D28}=2'b10; len = 28 if 2'b01; 2'b00 and 2'b11 are illegal.
//   Leap rule:
//     LY = year[0] | (yr_mod10==0).
//     yr_mod10 is a 0..9 wrap counter kept alongside year; no divider.
//     LY is registered; it updates in the same cycle as year.
//   Priority each cycle: reset > load > sol_tick > hold.
//   Load (load=1):
//     - Accept iff load_month<=23 and 1<=load_sol<=28.
//     - Accept: year/M/sol take load values next edge; yr_mod10 = load_year % 10,
//       computed by a constant-time lookup or iterative-free logic; sol_tick is ignored.
//     - Reject: state unchanged, load_err=1 for one cycle.
//   Tick (sol_tick=1, no load):
//     - If {D27,D28} is illegal: state holds, err<=1 (sticky until reset).
//     - Else if sol < len: sol<=sol+1.
//     - Else (sol>=len, covers an over-range loaded sol):
//         sol<=1, month_end<=1;
//         if M==23: M<=0, year<=year+1, yr_mod10 wraps 9->0, year_end<=1;
//         else M<=M+1.
//   Latency:
//     - Outputs change on the edge after the tick/load.
//     - D27/D28 are combinational from the registered M/LY, so they are stable
//       for the whole cycle.
//   year wraps 2**YEAR_W-1 -> 0. yr_mod10 then continues its own count.
//   Pulses are high exactly one cycle after the causing edge and never stretch.
//   Back-to-back ticks are allowed on every cycle.
// TESTING
//   1) Reset, then no tick for 5 cycles -> year=0, M=0, sol=1, LY=1,
//      pulses 0, err=0.
//   2) Load y=3, M=4, sol=27 with D27=1, then tick -> sol=1, M=5,
//      month_end=1 for one cycle.
//   3) Load y=9, M=23, sol=28 with D28=1, then tick -> year=10, M=0, sol=1,
//      month_end=year_end=1, LY=1 (mod10=0).
//   4) Load month=24 or sol=0 -> load_err=1 for one cycle, state unchanged.
//      Load and tick in the same cycle -> load wins.
//   5) Drive {D27,D28}=2'b11, then tick -> state holds and err=1.
//      err stays 1 across later legal ticks until reset.
//   6) Loop with a real martian_days instance for 2 full years of ticks ->
//      sol/month sequence matches a reference model and LY alternates 1,1.

Source files
------------

// File: rtl/martian_date_counter.sv
// Darian (Martian) calendar date counter.
// Holds year / month / sol, advances by one sol per sol_tick, and accepts a
// checked parallel load. Month length arrives from an external martian_days
// block as the D27/D28 flags, which in turn are derived from our M and LY.
module martian_date_counter #(
    parameter int YEAR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sol_tick,
    input  logic              load,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [4:0]        load_month,
    input  logic [4:0]        load_sol,
    input  logic              D27,
    input  logic              D28,
    output logic [YEAR_W-1:0] year,
    output logic [4:0]        M,
    output logic [4:0]        sol,
    output logic              LY,
    output logic              month_end,
    output logic              year_end,
    output logic              load_err,
    output logic              err
);

    // Residue of the year modulo 10, kept in step with year so the leap rule
    // needs no divider.
    logic [3:0] yr_mod10;

    logic [YEAR_W-1:0] year_n;
    logic [4:0]        m_n;
    logic [4:0]        sol_n;
    logic [3:0]        mod_n;
    logic              ly_n;
    logic              month_end_n;
    logic              year_end_n;
    logic              load_err_n;
    logic              err_n;

    logic              load_ok;
    logic              len_legal;
    logic [4:0]        month_len;
    logic [3:0]        load_mod10;

    // Year modulo 10 as a flat sum of per-bit residues (2^i mod 10 cycles
    // 1,2,4,8,6,2,4,8,6...). The loop unrolls into a fixed adder chain.
    function automatic logic [3:0] mod10(input logic [YEAR_W-1:0] v);
        logic [4:0] acc;
        logic [4:0] w;
        acc = 5'd0;
        w   = 5'd1;
        for (int i = 0; i < YEAR_W; i++) begin
            if (v[i]) begin
                acc = acc + w;
                if (acc >= 5'd10) begin
                    acc = acc - 5'd10;
                end
            end
            w = {w[3:0], 1'b0};
            if (w >= 5'd10) begin
                w = w - 5'd10;
            end
        end
        return acc[3:0];
    endfunction

    assign load_ok    = (load_month <= 5'd23) && (load_sol >= 5'd1) && (load_sol <= 5'd28);
    assign len_legal  = D27 ^ D28;
    assign month_len  = D27 ? 5'd27 : 5'd28;
    assign load_mod10 = mod10(load_year);

    // Next-state selection: load beats tick beats hold; pulses default low.
    always_comb begin
        year_n      = year;
        m_n         = M;
        sol_n       = sol;
        mod_n       = yr_mod10;
        month_end_n = 1'b0;
        year_end_n  = 1'b0;
        load_err_n  = 1'b0;
        err_n       = err;

        if (load) begin
            if (load_ok) begin
                year_n = load_year;
                m_n    = load_month;
                sol_n  = load_sol;
                mod_n  = load_mod10;
            end else begin
                load_err_n = 1'b1;
            end
        end else if (sol_tick) begin
            if (!len_legal) begin
                err_n = 1'b1;
            end else if (sol < month_len) begin
                sol_n = sol + 5'd1;
            end else begin
                // Also catches a loaded sol 28 in a 27-sol month.
                sol_n       = 5'd1;
                month_end_n = 1'b1;
                if (M == 5'd23) begin
                    m_n        = 5'd0;
                    year_n     = year + {{(YEAR_W-1){1'b0}}, 1'b1};
                    mod_n      = (yr_mod10 == 4'd9) ? 4'd0 : yr_mod10 + 4'd1;
                    year_end_n = 1'b1;
                end else begin
                    m_n = M + 5'd1;
                end
            end
        end

        ly_n = year_n[0] | (mod_n == 4'd0);
    end

    // State and output registers; LY is registered alongside year.
    always_ff @(posedge clk) begin
        if (reset) begin
            year      <= '0;
            M         <= 5'd0;
            sol       <= 5'd1;
            yr_mod10  <= 4'd0;
            LY        <= 1'b1;
            month_end <= 1'b0;
            year_end  <= 1'b0;
            load_err  <= 1'b0;
            err       <= 1'b0;
        end else begin
            year      <= year_n;
            M         <= m_n;
            sol       <= sol_n;
            yr_mod10  <= mod_n;
            LY        <= ly_n;
            month_end <= month_end_n;
            year_end  <= year_end_n;
            load_err  <= load_err_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_martian_date_counter.sv
// Self-checking bench for martian_date_counter: directed scenarios plus a
// randomized run, all compared against a date model kept in absolute years.
module tb_martian_date_counter;

    localparam int YEAR_W = 12;
    localparam int YEAR_MOD = 1 << YEAR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              sol_tick;
    logic              load;
    logic [YEAR_W-1:0] load_year;
    logic [4:0]        load_month;
    logic [4:0]        load_sol;
    logic              D27;
    logic              D28;
    logic [YEAR_W-1:0] year;
    logic [4:0]        month;
    logic [4:0]        sol;
    logic              ly;
    logic              month_end;
    logic              year_end;
    logic              load_err;
    logic              err;

    logic              force_en;
    logic [1:0]        force_code;
    logic              md27;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute year count, so year wrap and the mod-10
    // residue fall out of plain arithmetic.
    int m_ytot;
    int m_mon;
    int m_sol;
    bit m_err;
    bit m_me;
    bit m_ye;
    bit m_le;

    martian_date_counter #(.YEAR_W(YEAR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sol_tick   (sol_tick),
        .load       (load),
        .load_year  (load_year),
        .load_month (load_month),
        .load_sol   (load_sol),
        .D27        (D27),
        .D28        (D28),
        .year       (year),
        .M          (month),
        .sol        (sol),
        .LY         (ly),
        .month_end  (month_end),
        .year_end   (year_end),
        .load_err   (load_err),
        .err        (err)
    );

    // Stand-in for martian_days: every sixth month is 27 sols, except the
    // last month of a leap year which is 28.
    assign md27 = ((month % 5'd6) == 5'd5) && !((month == 5'd23) && ly);
    assign D27  = force_en ? force_code[1] : md27;
    assign D28  = force_en ? force_code[0] : !md27;

    always #5 clk = ~clk;

    function automatic bit modelLeap(input int yt);
        return ((yt % 2) == 1) || ((yt % 10) == 0);
    endfunction

    function automatic int modelLen(input int mon, input int yt);
        if (((mon % 6) == 5) && !((mon == 23) && modelLeap(yt))) return 27;
        return 28;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareState();
        checkOutput("year", 32'(year), 32'(m_ytot % YEAR_MOD));
        checkOutput("month", 32'(month), 32'(m_mon));
        checkOutput("sol", 32'(sol), 32'(m_sol));
        checkOutput("flags", 32'({ly, month_end, year_end, load_err, err}),
                    32'({modelLeap(m_ytot), m_me, m_ye, m_le, m_err}));
    endtask

    task automatic modelReset();
        m_ytot = 0; m_mon = 0; m_sol = 1; m_err = 0;
        m_me = 0; m_ye = 0; m_le = 0;
    endtask

    // One clock of the reference date rules, given this cycle's inputs.
    task automatic modelStep(input bit do_load, input int ly_v, input int lm, input int ls,
                             input bit tick, input bit frc, input logic [1:0] code);
        int len;
        logic [1:0] c;
        m_me = 0; m_ye = 0; m_le = 0;
        if (do_load) begin
            if (lm <= 23 && ls >= 1 && ls <= 28) begin
                m_ytot = ly_v; m_mon = lm; m_sol = ls;
            end else begin
                m_le = 1;
            end
        end else if (tick) begin
            len = modelLen(m_mon, m_ytot);
            c = frc ? code : ((len == 27) ? 2'b10 : 2'b01);
            if (c == 2'b00 || c == 2'b11) begin
                m_err = 1;
            end else begin
                len = (c == 2'b10) ? 27 : 28;
                if (m_sol < len) begin
                    m_sol++;
                end else begin
                    m_sol = 1; m_me = 1;
                    if (m_mon == 23) begin
                        m_mon = 0; m_ytot++; m_ye = 1;
                    end else begin
                        m_mon++;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit do_load, input int ly_v, input int lm, input int ls,
                                 input bit tick, input bit frc, input logic [1:0] code);
        load       = do_load;
        load_year  = ly_v[YEAR_W-1:0];
        load_month = lm[4:0];
        load_sol   = ls[4:0];
        sol_tick   = tick;
        force_en   = frc;
        force_code = code;
        modelStep(do_load, ly_v, lm, ls, tick, frc, code);
        @(negedge clk);
        load     = 1'b0;
        sol_tick = 1'b0;
        force_en = 1'b0;
        compareState();
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        compareState();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, 0, 2'b00);
    endtask

    initial begin
        int r;
        reset = 1'b1; sol_tick = 1'b0; load = 1'b0;
        load_year = '0; load_month = '0; load_sol = '0;
        force_en = 1'b0; force_code = 2'b00;
        @(negedge clk);

        // Reset and idle.
        doReset();
        idle(5);
        checkOutput("rst_sol", 32'(sol), 32'd1);
        checkOutput("rst_ly", 32'(ly), 32'd1);

        // 27-sol month rollover.
        applyStimulus(1, 3, 4, 27, 0, 0, 2'b00);
        applyStimulus(0, 0, 0, 0, 1, 1, 2'b10);
        checkOutput("t2_month", 32'(month), 32'd5);
        checkOutput("t2_month_end", 32'(month_end), 32'd1);
        idle(1);
        checkOutput("t2_pulse_drop", 32'(month_end), 32'd0);

        // Year rollover 9 -> 10, still leap through the mod-10 residue.
        applyStimulus(1, 9, 23, 28, 0, 0, 2'b00);
        applyStimulus(0, 0, 0, 0, 1, 1, 2'b01);
        checkOutput("t3_year", 32'(year), 32'd10);
        checkOutput("t3_year_end", 32'(year_end), 32'd1);
        checkOutput("t3_ly", 32'(ly), 32'd1);
        idle(1);

        // Rejected loads, then load versus tick priority.
        applyStimulus(1, 77, 24, 5, 0, 0, 2'b00);
        checkOutput("t4_load_err", 32'(load_err), 32'd1);
        applyStimulus(1, 77, 3, 0, 0, 0, 2'b00);
        applyStimulus(1, 77, 3, 29, 1, 0, 2'b00);
        applyStimulus(1, 123, 7, 12, 1, 0, 2'b00);
        checkOutput("t4_load_wins", 32'(sol), 32'd12);
        idle(1);

        // Over-range loaded sol 28 in a 27-sol month rolls over at once.
        applyStimulus(1, 20, 11, 28, 0, 0, 2'b00);
        tick(2);

        // Year wrap: residue continues, so 4095 -> 0 is not a leap year.
        applyStimulus(1, YEAR_MOD - 1, 23, 28, 0, 0, 2'b00);
        applyStimulus(0, 0, 0, 0, 1, 1, 2'b01);
        checkOutput("wrap_year", 32'(year), 32'd0);
        checkOutput("wrap_ly", 32'(ly), 32'd0);

        // Illegal month-length flags: hold and sticky error.
        applyStimulus(0, 0, 0, 0, 1, 1, 2'b11);
        checkOutput("t5_err", 32'(err), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 2'b00);
        tick(3);
        checkOutput("t5_sticky", 32'(err), 32'd1);
        doReset();

        // Two full years in the loop with the month-length stand-in.
        for (int i = 0; i < 669 + 669; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 2'b00);
            if ($urandom_range(0, 9) == 0) idle(1);
        end
        checkOutput("t6_year", 32'(year), 32'd2);
        checkOutput("t6_date", 32'({month, sol}), 32'({5'd0, 5'd1}));

        // Randomized mix of loads, ticks, gaps and occasional bad flags.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                doReset();
            end else if (r < 12) begin
                applyStimulus(1, $urandom_range(0, YEAR_MOD - 1), $urandom_range(0, 31),
                              $urandom_range(0, 31), bit'($urandom_range(0, 1)), 0, 2'b00);
            end else if (r < 15) begin
                applyStimulus(0, 0, 0, 0, 1, 1, 2'($urandom_range(0, 3)));
            end else if (r < 150) begin
                tick(1);
            end else begin
                idle(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
